// File: rtl/aes_round_ctrl_pkg.sv
// aes_pkg: shared AES-128 types, constants and byte-level helpers for the
// iterative round controller. State layout is [row][col], where byte 4c+r of
// the 128-bit block (byte 0 = bits [127:120]) lands in s[r][c].
package aes_pkg;

  localparam int NR = 10;

  typedef logic [3:0][3:0][7:0] aes_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } aes_fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8); reduction polynomial folds back as 8'h1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10; zero outside that range so IDLE never
  // indexes past the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

  function automatic aes_state_t to_state(input logic [127:0] v);
    aes_state_t s;
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = v[127 - 8 * (4 * c + r) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input aes_state_t s);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[127 - 8 * (4 * c + r) -: 8] = s[r][c];
    return v;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: host-side bundle for the AES-128 round controller.
// Handshake: the host holds start with pt_in/key_in; a block is accepted on
// a rising edge where start && ready. ct_valid is a one-cycle pulse marking
// the edge ct_out changed; there is no backpressure on the result.
// The abort signal exists only when AES_ABORT_EN is defined.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic         start;
  logic [127:0] pt_in;
  logic [127:0] key_in;
  logic         ready;
  logic         busy;
  logic [127:0] ct_out;
  logic         ct_valid;
  logic [3:0]   round;
  aes_fsm_t     fsm_state;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  modport master (
`ifdef AES_ABORT_EN
    output abort,
`endif
    output start, pt_in, key_in,
    input  ready, busy, ct_out, ct_valid, round, fsm_state
  );

  modport slave (
`ifdef AES_ABORT_EN
    input  abort,
`endif
    input  start, pt_in, key_in,
    output ready, busy, ct_out, ct_valid, round, fsm_state
  );

endinterface

// File: rtl/aes_round_ctrl_key_step.sv
// aes_key_step: one AES-128 key-schedule step, producing the next round key
// from the current one and the round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, rot, sub, w4, w5, w6, w7;

  // RotWord, SubWord and rcon feed w4; the rest chain by XOR.
  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w4 = w0 ^ sub ^ {rcon, 24'h000000};
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;
    next_key = {w4, w5, w6, w7};
  end

endmodule

// File: rtl/aes_round_ctrl_mix_column.sv
// mix_column: combinational MixColumns over all four columns of a state,
// indexed [row][col].
module mix_column
  import aes_pkg::*;
(
  input  aes_state_t din,
  output aes_state_t dout
);

  // Each output byte is the fixed {02,03,01,01} circulant applied to its column.
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      dout[0][c] = xtime(din[0][c]) ^ xtime(din[1][c]) ^ din[1][c] ^ din[2][c] ^ din[3][c];
      dout[1][c] = din[0][c] ^ xtime(din[1][c]) ^ xtime(din[2][c]) ^ din[2][c] ^ din[3][c];
      dout[2][c] = din[0][c] ^ din[1][c] ^ xtime(din[2][c]) ^ xtime(din[3][c]) ^ din[3][c];
      dout[3][c] = xtime(din[0][c]) ^ din[0][c] ^ din[1][c] ^ din[2][c] ^ xtime(din[3][c]);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryptor. One round datapath is reused
// for rounds 1..10; round keys are expanded on the fly from key_reg.
// Optional feature macro: AES_ABORT_EN (adds the abort input).
module aes_round_ctrl
  import aes_pkg::*;
(
  input logic              clk,
  input logic              rst,
  aes_round_ctrl_if.slave  bus
);

  aes_fsm_t     fsm;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] ct_q;
  logic         ct_valid_q;
  logic         ready_q;
  logic [3:0]   round_q;

  aes_state_t   s_cur;
  aes_state_t   s_sub;
  aes_state_t   s_shift;
  aes_state_t   s_mix;
  logic [127:0] round_key;
  logic [127:0] round_out;
  logic [7:0]   rcon_cur;
  logic         last_round;
  logic         abort_hit;

`ifdef AES_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign rcon_cur   = rcon_of(round_q);
  assign last_round = (round_q == 4'(NR));

  // SubBytes then ShiftRows: row r rotates left by r columns.
  always_comb begin
    s_cur   = to_state(state_reg);
    s_sub   = '0;
    s_shift = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s_sub[r][c] = sbox(s_cur[r][c]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s_shift[r][c] = s_sub[r][2'(c + r)];
  end

  mix_column u_mix (
    .din  (s_shift),
    .dout (s_mix)
  );

  aes_key_step u_key (
    .key      (key_reg),
    .rcon     (rcon_cur),
    .next_key (round_key)
  );

  // Final round bypasses MixColumns, then AddRoundKey with K(round).
  always_comb begin
    round_out = from_state(last_round ? s_shift : s_mix) ^ round_key;
  end

  // Sequencer: accepts in IDLE, runs ten rounds, publishes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      key_reg    <= '0;
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      round_q    <= 4'd0;
    end else begin
      ct_valid_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            state_reg <= bus.pt_in ^ bus.key_in;
            key_reg   <= bus.key_in;
            round_q   <= 4'd1;
            ready_q   <= 1'b0;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          if (abort_hit) begin
            round_q <= 4'd0;
            ready_q <= 1'b1;
            fsm     <= IDLE;
          end else begin
            state_reg <= round_out;
            key_reg   <= round_key;
            if (last_round) begin
              ct_q       <= round_out;
              ct_valid_q <= 1'b1;
              round_q    <= 4'd0;
              ready_q    <= 1'b1;
              fsm        <= IDLE;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: begin
          round_q <= 4'd0;
          ready_q <= 1'b1;
          fsm     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = ~ready_q;
  assign bus.ct_out    = ct_q;
  assign bus.ct_valid  = ct_valid_q;
  assign bus.round     = round_q;
  assign bus.fsm_state = fsm;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl using FIPS-197 vectors.
// Define AES_ABORT_EN for both RTL and bench to exercise the abort path.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every ct_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.ct_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", 128'(1), 128'(0));
      else check("ct_out", bus.ct_out, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns 1ns after the accepting edge with start low.
  task automatic do_start(input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp, input bit push);
    bus.start  = 1'b1;
    bus.pt_in  = pt;
    bus.key_in = key;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until ct_valid; returns at that negedge.
  task automatic wait_done(input string tag, input bit check_rounds);
    int cycles;
    bit seen;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (check_rounds && cycles <= 11)
        check({tag, "_round"}, 128'(bus.round), 128'(cycles <= 10 ? cycles : 0));
      if (cycles == 1) check({tag, "_ready_low"}, 128'(bus.ready), 128'(0));
      if (bus.ct_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, 128'(cycles), 128'(11));
    check({tag, "_ready_hi"}, 128'(bus.ready), 128'(1));
    check({tag, "_busy_lo"}, 128'(bus.busy), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 128'(bus.ready), 128'(1));
    check({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check({tag, "_round"}, 128'(bus.round), 128'(0));
    check({tag, "_valid"}, 128'(bus.ct_valid), 128'(0));
    check({tag, "_ct"}, bus.ct_out, 128'(0));
    check({tag, "_fsm"}, 128'(bus.fsm_state), 128'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.pt_in  = '0;
    bus.key_in = '0;
`ifdef AES_ABORT_EN
    bus.abort  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // App. B single block, latency check
    do_start(PB, KB, CB, 1'b1);
    wait_done("appb", 1'b0);
    @(negedge clk);

    // C.1 with round stepping
    do_start(PC, KC, CC, 1'b1);
    wait_done("c1", 1'b1);
    @(negedge clk);

    // Back-to-back: second start lands in the ct_valid cycle
    do_start(PB, KB, CB, 1'b1);
    wait_done("b2b_a", 1'b0);
    do_start(PC, KC, CC, 1'b1);
    wait_done("b2b_b", 1'b0);

    // start held 20 cycles, inputs switch mid-run
    for (int i = 0; i < 20; i++) begin
      bus.start = 1'b1;
      if (i < 3) begin
        bus.pt_in  = PB;
        bus.key_in = KB;
      end else begin
        bus.pt_in  = PC;
        bus.key_in = KC;
      end
      check("hold_ready", 128'(bus.ready), 128'(i == 0 || i == 11));
      if (i == 0)  exp_q.push_back(CB);
      if (i == 11) exp_q.push_back(CC);
      @(negedge clk);
    end
    bus.start = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("hold_drain", 128'(exp_q.size()), 128'(0));
    @(negedge clk);

    // Reset asserted at round 5
    do_start(PC, KC, CC, 1'b1);
    guard = 0;
    while (bus.round != 4'd5 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach_r5", 128'(bus.round), 128'(5));
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("midrst_quiet", 128'(bus.ct_out), 128'(0));
    do_start(PC, KC, CC, 1'b1);
    wait_done("post_rst", 1'b0);
    @(negedge clk);

`ifdef AES_ABORT_EN
    // Abort at round 10: no result, previous ciphertext kept
    do_start(PB, KB, CB, 1'b0);
    guard = 0;
    while (bus.round != 4'd10 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach_r10", 128'(bus.round), 128'(10));
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_valid", 128'(bus.ct_valid), 128'(0));
    check("abort_ready", 128'(bus.ready), 128'(1));
    check("abort_round", 128'(bus.round), 128'(0));
    check("abort_ct_kept", bus.ct_out, CC);
    repeat (3) @(negedge clk);
    // abort in IDLE alongside start is ignored
    bus.abort = 1'b1;
    do_start(PB, KB, CB, 1'b1);
    bus.abort = 1'b0;
    wait_done("abort_idle", 1'b0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("final_queue", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
